// File: rtl/irrigation_sequencer_pkg.sv
// Shared encodings for the irrigation sequencer: FSM states, grant owner,
// and the mapping from (state, grant) to pump/valve drive levels.
package irrigation_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_OPEN     = 3'd1,
    ST_RUN      = 3'd2,
    ST_STOP     = 3'd3,
    ST_COOLDOWN = 3'd4,
    ST_FAULT    = 3'd5
  } state_t;

  localparam logic GRANT_DRIP      = 1'b0;
  localparam logic GRANT_SPRINKLER = 1'b1;

  typedef struct packed {
    logic pump;
    logic drip_valve;
    logic sprinkler_valve;
  } drive_t;

  // Only the granted valve may open, and the pump runs only in RUN, so the
  // valves are exclusive and the pump always has exactly one open path.
  function automatic drive_t decode_drive(input state_t st, input logic grant);
    drive_t d;
    d = '0;
    case (st)
      ST_OPEN, ST_STOP: begin
        d.drip_valve      = (grant == GRANT_DRIP);
        d.sprinkler_valve = (grant == GRANT_SPRINKLER);
      end
      ST_RUN: begin
        d.pump            = 1'b1;
        d.drip_valve      = (grant == GRANT_DRIP);
        d.sprinkler_valve = (grant == GRANT_SPRINKLER);
      end
      default: d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/irrigation_sequencer_bit_sync.sv
// Two-flop synchronizer for a single asynchronous level input.
module bit_sync (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o
);

  logic r_meta;
  logic r_sync;

  // Capture the async level, then re-register to let metastability settle.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= d_i;
      r_sync <= r_meta;
    end
  end

  assign q_o = r_sync;

endmodule

// File: rtl/irrigation_sequencer.sv
// Shares one pump/tank between drip and sprinkler requesters. Each grant runs
// OPEN (valve settles) -> RUN (pump on) -> STOP (valve drains) -> COOLDOWN.
// A tank running dry while pumping latches FAULT until cleared with water back.
module irrigation_sequencer #(
  parameter int SETTLE_CYCLES  = 4,
  parameter int MAX_ON_CYCLES  = 1024,
  parameter int MIN_OFF_CYCLES = 256,
  parameter int CNT_W          = 16
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       enable_i,
  input  logic       drip_req_i,
  input  logic       sprinkler_req_i,
  input  logic       low_level_i,
  input  logic       medium_level_i,
  input  logic       fault_clr_i,
  output logic       pump_o,
  output logic       drip_valve_o,
  output logic       sprinkler_valve_o,
  output logic       grant_o,
  output logic       busy_o,
  output logic       fault_o,
  output logic [2:0] state_o
);

  import irrigation_sequencer_pkg::*;

  // Counter reload values: each timed state lasts (value + 1) cycles.
  localparam logic [CNT_W-1:0] LP_SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_MAXON_LD  = CNT_W'(MAX_ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_MINOFF_LD = CNT_W'(MIN_OFF_CYCLES - 1);

  logic w_enable;
  logic w_drip_req;
  logic w_spr_req;
  logic w_low;
  logic w_med;

  // fault_clr_i is already a synchronous pulse and is used directly.
  bit_sync u_sync_enable (.clk_i(clk_i), .rst_n_i(rst_n_i), .d_i(enable_i),        .q_o(w_enable));
  bit_sync u_sync_drip   (.clk_i(clk_i), .rst_n_i(rst_n_i), .d_i(drip_req_i),      .q_o(w_drip_req));
  bit_sync u_sync_spr    (.clk_i(clk_i), .rst_n_i(rst_n_i), .d_i(sprinkler_req_i), .q_o(w_spr_req));
  bit_sync u_sync_low    (.clk_i(clk_i), .rst_n_i(rst_n_i), .d_i(low_level_i),     .q_o(w_low));
  bit_sync u_sync_med    (.clk_i(clk_i), .rst_n_i(rst_n_i), .d_i(medium_level_i),  .q_o(w_med));

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_grant;
  logic             r_last_grant;
  drive_t           r_drive;
  logic             r_busy;
  logic             r_fault;

  logic             w_drip_elig;
  logic             w_spr_elig;
  logic             w_granted_elig;
  logic [CNT_W-1:0] w_cnt_dec;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_grant_nxt;
  logic             w_last_nxt;

  assign w_drip_elig    = w_enable & w_drip_req & w_low;
  assign w_spr_elig     = w_enable & w_spr_req & w_med;
  assign w_granted_elig = (r_grant == GRANT_SPRINKLER) ? w_spr_elig : w_drip_elig;
  // Saturating decrement: the counter parks at zero instead of wrapping.
  assign w_cnt_dec      = (r_cnt != '0) ? (r_cnt - 1'b1) : '0;

  // Next-state, counter reload and arbitration decisions.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_grant_nxt = r_grant;
    w_last_nxt  = r_last_grant;
    case (r_state)
      ST_IDLE: begin
        if (w_drip_elig && w_spr_elig) begin
          w_grant_nxt = ~r_last_grant;
          w_state_nxt = ST_OPEN;
          w_cnt_nxt   = LP_SETTLE_LD;
        end else if (w_drip_elig) begin
          w_grant_nxt = GRANT_DRIP;
          w_state_nxt = ST_OPEN;
          w_cnt_nxt   = LP_SETTLE_LD;
        end else if (w_spr_elig) begin
          w_grant_nxt = GRANT_SPRINKLER;
          w_state_nxt = ST_OPEN;
          w_cnt_nxt   = LP_SETTLE_LD;
        end
      end
      ST_OPEN: begin
        if (!w_granted_elig) begin
          w_state_nxt = ST_STOP;
          w_cnt_nxt   = LP_SETTLE_LD;
        end else if (r_cnt == '0) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = LP_MAXON_LD;
        end else begin
          w_cnt_nxt   = w_cnt_dec;
        end
      end
      ST_RUN: begin
        // Dry-run outranks every other exit, including a request drop.
        if (!w_low) begin
          w_state_nxt = ST_FAULT;
          w_cnt_nxt   = '0;
        end else if (!w_granted_elig || (r_cnt == '0)) begin
          w_state_nxt = ST_STOP;
          w_cnt_nxt   = LP_SETTLE_LD;
        end else begin
          w_cnt_nxt   = w_cnt_dec;
        end
      end
      ST_STOP: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_COOLDOWN;
          w_cnt_nxt   = LP_MINOFF_LD;
          w_last_nxt  = r_grant;
        end else begin
          w_cnt_nxt   = w_cnt_dec;
        end
      end
      ST_COOLDOWN: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt   = w_cnt_dec;
        end
      end
      ST_FAULT: begin
        if (fault_clr_i && w_low) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // State register; outputs decoded from next-state so drives switch with the state.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_grant      <= GRANT_DRIP;
      r_last_grant <= GRANT_SPRINKLER;
      r_drive      <= '0;
      r_busy       <= 1'b0;
      r_fault      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_grant      <= w_grant_nxt;
      r_last_grant <= w_last_nxt;
      r_drive      <= decode_drive(w_state_nxt, w_grant_nxt);
      r_busy       <= (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_FAULT);
      r_fault      <= (w_state_nxt == ST_FAULT);
    end
  end

  assign pump_o            = r_drive.pump;
  assign drip_valve_o      = r_drive.drip_valve;
  assign sprinkler_valve_o = r_drive.sprinkler_valve;
  assign grant_o           = r_grant;
  assign busy_o            = r_busy;
  assign fault_o           = r_fault;
  assign state_o           = r_state;

endmodule

// File: tb/tb_irrigation_sequencer.sv
// Directed bench for irrigation_sequencer with SETTLE=2, MAX_ON=10, MIN_OFF=5.
module tb_irrigation_sequencer;

  localparam int S = 2;
  localparam int M = 10;
  localparam int O = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0, drip = 1'b0, spr = 1'b0, low = 1'b0, med = 1'b0, clr = 1'b0;
  logic       pump_o, drip_valve_o, sprinkler_valve_o, grant_o, busy_o, fault_o;
  logic [2:0] state_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  irrigation_sequencer #(
    .SETTLE_CYCLES(S), .MAX_ON_CYCLES(M), .MIN_OFF_CYCLES(O), .CNT_W(16)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .enable_i(en), .drip_req_i(drip),
    .sprinkler_req_i(spr), .low_level_i(low), .medium_level_i(med),
    .fault_clr_i(clr), .pump_o(pump_o), .drip_valve_o(drip_valve_o),
    .sprinkler_valve_o(sprinkler_valve_o), .grant_o(grant_o), .busy_o(busy_o),
    .fault_o(fault_o), .state_o(state_o)
  );

  typedef struct {
    string      name;
    logic       d;
    logic       s;
    int         ticks;
    logic [8:0] exp;
  } vec_t;

  vec_t vq[$];

  // Expected-output packing: {pump, drip_v, spr_v, grant, busy, fault, state}
  function automatic logic [8:0] ex(input logic p, input logic dv, input logic sv,
                                    input logic g, input logic b, input logic f,
                                    input logic [2:0] st);
    return {p, dv, sv, g, b, f, st};
  endfunction

  function automatic vec_t mk(input string nm, input logic d, input logic s,
                              input int t, input logic [8:0] e);
    vec_t v;
    v.name = nm; v.d = d; v.s = s; v.ticks = t; v.exp = e;
    return v;
  endfunction

  function automatic logic [8:0] act();
    return {pump_o, drip_valve_o, sprinkler_valve_o, grant_o, busy_o, fault_o, state_o};
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string nm, input logic [8:0] e);
    logic [8:0] a;
    a = act();
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %b want %b (pump,dv,sv,grant,busy,fault,state)", nm, a, e);
    end
  endtask

  task automatic check_val(input string nm, input int a, input int e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, a, e);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  localparam logic [8:0] E_IDLE  = 9'b000_000_000;

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [8:0] e_open_d, e_run_d, e_stop_d, e_cool;
    logic       gq[$];
    int         viol;
    logic [2:0] prev_st;
    e_open_d = ex(0, 1, 0, 0, 1, 0, 3'd1);
    e_run_d  = ex(1, 1, 0, 0, 1, 0, 3'd2);
    e_stop_d = ex(0, 1, 0, 0, 1, 0, 3'd3);
    e_cool   = ex(0, 0, 0, 0, 1, 0, 3'd4);

    // Reset state
    tick(2);
    check("reset_outputs", E_IDLE);
    en = 1'b1; low = 1'b1; med = 1'b1;
    rst_n = 1'b1;
    tick(3);
    check("idle_after_reset", E_IDLE);

    // Table: drip grant with early drop, then held drip through a full max-on run
    vq.push_back(mk("t1_sync_wait",  1, 0, 2, E_IDLE));
    vq.push_back(mk("t1_open",       1, 0, 1, e_open_d));
    vq.push_back(mk("t1_open_hold",  1, 0, 1, e_open_d));
    vq.push_back(mk("t1_run",        1, 0, 1, e_run_d));
    vq.push_back(mk("t1_drop_run",   0, 0, 2, e_run_d));
    vq.push_back(mk("t1_stop",       0, 0, 1, e_stop_d));
    vq.push_back(mk("t1_stop_hold",  0, 0, 1, e_stop_d));
    vq.push_back(mk("t1_cool",       0, 0, 1, e_cool));
    vq.push_back(mk("t1_cool_hold",  0, 0, 4, e_cool));
    vq.push_back(mk("t1_idle",       0, 0, 1, E_IDLE));
    vq.push_back(mk("t2_open",       1, 0, 3, e_open_d));
    vq.push_back(mk("t2_run",        1, 0, 2, e_run_d));
    vq.push_back(mk("t2_run_last",   1, 0, 9, e_run_d));
    vq.push_back(mk("t2_stop_maxon", 1, 0, 1, e_stop_d));
    vq.push_back(mk("t2_cool",       1, 0, 2, e_cool));
    vq.push_back(mk("t2_cool_last",  1, 0, 4, e_cool));
    vq.push_back(mk("t2_idle",       1, 0, 1, E_IDLE));
    vq.push_back(mk("t2_regrant",    1, 0, 1, e_open_d));
    vq.push_back(mk("t2_drop_open",  0, 0, 2, e_run_d));
    vq.push_back(mk("t2_drop_stop",  0, 0, 1, e_stop_d));
    vq.push_back(mk("t2_cool2",      0, 0, 2, e_cool));
    vq.push_back(mk("t2_idle2",      0, 0, 5, E_IDLE));

    foreach (vq[i]) begin
      drip = vq[i].d;
      spr  = vq[i].s;
      tick(vq[i].ticks);
      check(vq[i].name, vq[i].exp);
    end

    // Both requesters held from reset: round-robin drip, sprinkler, drip
    drip = 1'b1; spr = 1'b1; en = 1'b1; low = 1'b1; med = 1'b1;
    do_reset();
    viol = 0;
    prev_st = state_o;
    for (int c = 0; c < 100 && gq.size() < 3; c++) begin
      tick(1);
      if (drip_valve_o && sprinkler_valve_o) viol++;
      if (pump_o && !(drip_valve_o ^ sprinkler_valve_o)) viol++;
      if (prev_st != 3'd1 && state_o == 3'd1) gq.push_back(grant_o);
      prev_st = state_o;
    end
    check_val("t3_grant_count", gq.size(), 3);
    check_val("t3_grant0_drip",      (gq.size() > 0) ? int'(gq[0]) : -1, 0);
    check_val("t3_grant1_sprinkler", (gq.size() > 1) ? int'(gq[1]) : -1, 1);
    check_val("t3_grant2_drip",      (gq.size() > 2) ? int'(gq[2]) : -1, 0);
    check_val("t3_exclusive_violations", viol, 0);

    // Sprinkler blocked by medium permit, granted once the permit arrives
    drip = 1'b0; spr = 1'b1; med = 1'b0;
    do_reset();
    tick(8);
    check("t4_no_permit", E_IDLE);
    med = 1'b1;
    tick(2);
    check("t4_permit_sync", E_IDLE);
    tick(1);
    check("t4_spr_open", ex(0, 0, 1, 1, 1, 0, 3'd1));

    // Dry-run during RUN, fault clear gated on level
    spr = 1'b0; drip = 1'b1;
    do_reset();
    tick(3);
    check("t5_open", e_open_d);
    tick(2);
    check("t5_run", e_run_d);
    low = 1'b0;
    tick(2);
    check("t5_dry_sync", e_run_d);
    tick(1);
    check("t5_fault", ex(0, 0, 0, 0, 0, 1, 3'd5));
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    check("t5_clr_no_water", ex(0, 0, 0, 0, 0, 1, 3'd5));
    low = 1'b1;
    tick(3);
    check("t5_water_back", ex(0, 0, 0, 0, 0, 1, 3'd5));
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    check("t5_cleared", E_IDLE);

    // Asynchronous reset in the middle of RUN
    tick(1);
    check("t6_open", e_open_d);
    tick(2);
    check("t6_run", e_run_d);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_drop", E_IDLE);
    drip = 1'b0;
    tick(1);
    check("t6_held_reset", E_IDLE);
    rst_n = 1'b1;
    tick(1);
    check("t6_after_release", E_IDLE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
